mips_mcp_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM; successor to the single-cycle control unit. Drives a multi-cycle

---
 rtl/mips_mcp_pkg.sv | 68 ++++++
 rtl/mips_alu_decode.sv | 25 ++
 rtl/mips_mcp_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mips_mcp_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mcp_pkg.sv
// Shared encodings for the multi-cycle MIPS control: states, opcodes, functs and mux selects.
// Pure constants and types; no timing or flow control of its own.
package mips_mcp_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTYPE  = 4'd6,
    ALUWB  = 4'd7,
    ADDI   = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    JAL    = 4'd11,
    JR     = 4'd12,
    TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_A      = 2'b11;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_ILL  = 2'b01;
  localparam logic [1:0] FLT_TMO  = 2'b10;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct to ALU control with a legality flag; purely combinational, zero latency.
// No flow control: the caller decides what an illegal funct means.
module mips_alu_decode
  import mips_mcp_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_NOR:  alu_control = ALU_NOR;
      FN_SLT:  alu_control = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mcp_ctrl.sv
// Multi-cycle MIPS control FSM; outputs decode state and inputs in the same cycle.
// Memory states hold mem_req until mem_ready; a stalled access traps after MEM_TIMEOUT cycles.
module mips_mcp_ctrl
  import mips_mcp_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 255,
  parameter int EN_BNE      = 1,
  parameter int EN_JAL      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic [1:0] fault,
  output logic [3:0] state
);

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_t                st_q, st_d;
  logic [TIMEOUT_W-1:0]  wait_q;
  logic [1:0]            fault_q, fault_d;
  logic [3:0]            rt_alu;
  logic                  rt_legal;
  logic                  tmo_hit;

  mips_alu_decode u_alu_decode (
    .funct       (funct),
    .alu_control (rt_alu),
    .legal       (rt_legal)
  );

  assign tmo_hit = (MEM_TIMEOUT != 0) && (wait_q == TMO_LAST);
  assign state   = st_q;
  assign fault   = fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= FETCH;
      wait_q  <= '0;
      fault_q <= FLT_NONE;
    end else begin
      st_q    <= st_d;
      fault_q <= fault_d;
      if (mem_req && !mem_ready && (st_d == st_q))
        wait_q <= wait_q + TIMEOUT_W'(1);
      else
        wait_q <= '0;
    end
  end

  always_comb begin
    st_d        = st_q;
    fault_d     = fault_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    mdr_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    alu_control = ALU_AND;
    reg_dst     = DST_RT;
    mem_to_reg  = M2R_ALU;
    reg_write   = 1'b0;
    // Gating on reset lets mem_req fall the moment reset rises, mid-access included.
    if (!reset) begin
      case (st_q)
        FETCH: begin
          mem_req     = 1'b1;
          alu_src_b   = SRCB_4;
          alu_control = ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            st_d     = DECODE;
          end
        end
        DECODE: begin
          alu_src_b   = SRCB_BR;
          alu_control = ALU_ADD;
          case (op)
            OP_LW, OP_SW: st_d = MEMADR;
            OP_RTYPE: begin
              if (funct != FN_JR)   st_d = RTYPE;
              else if (EN_JAL != 0) st_d = JR;
              else                  st_d = TRAP;
            end
            OP_BEQ:  st_d = BRANCH;
            OP_BNE:  st_d = (EN_BNE != 0) ? BRANCH : TRAP;
            OP_ADDI: st_d = ADDI;
            OP_J:    st_d = JUMP;
            OP_JAL:  st_d = (EN_JAL != 0) ? JAL : TRAP;
            default: st_d = TRAP;
          endcase
          if (st_d == TRAP) fault_d = FLT_ILL;
        end
        MEMADR: begin
          alu_src_a   = 1'b1;
          alu_src_b   = SRCB_IMM;
          alu_control = ALU_ADD;
          st_d        = (op == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            mdr_write = 1'b1;
            st_d      = MEMWB;
          end
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
          st_d       = FETCH;
        end
        MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) st_d = FETCH;
        end
        RTYPE: begin
          alu_src_a   = 1'b1;
          alu_control = rt_alu;
          if (rt_legal) st_d = ALUWB;
          else begin
            st_d    = TRAP;
            fault_d = FLT_ILL;
          end
        end
        ALUWB: begin
          // IR is still loaded, so op tells R-type and addi apart without extra state.
          reg_write = 1'b1;
          reg_dst   = (op == OP_RTYPE) ? DST_RD : DST_RT;
          st_d      = FETCH;
        end
        ADDI: begin
          alu_src_a   = 1'b1;
          alu_src_b   = SRCB_IMM;
          alu_control = ALU_ADD;
          st_d        = ALUWB;
        end
        BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_SUB;
          pc_src      = PC_ALUOUT;
          pc_write    = (op == OP_BNE) ? !zero : zero;
          st_d        = FETCH;
        end
        JUMP: begin
          pc_src   = PC_JUMP;
          pc_write = 1'b1;
          st_d     = FETCH;
        end
        JAL: begin
          reg_dst    = DST_RA;
          mem_to_reg = M2R_PC;
          reg_write  = 1'b1;
          pc_src     = PC_JUMP;
          pc_write   = 1'b1;
          st_d       = FETCH;
        end
        JR: begin
          pc_src   = PC_A;
          pc_write = 1'b1;
          st_d     = FETCH;
        end
        TRAP: st_d = TRAP;
        default: st_d = TRAP;
      endcase
      // mem_ready in the same cycle completes the access instead of timing out.
      if (mem_req && !mem_ready && tmo_hit) begin
        st_d    = TRAP;
        fault_d = FLT_TMO;
      end
    end
  end

endmodule

// File: tb/tb_mips_mcp_ctrl.sv
// Randomized instruction-level bench for mips_mcp_ctrl with a queue-based per-cycle scoreboard.
module tb_mips_mcp_ctrl;

  localparam int TO = 4;
  localparam int C_LW = 0, C_SW = 1, C_RT = 2, C_BR = 3, C_ADDI = 4,
                 C_J = 5, C_JAL = 6, C_JR = 7, C_ILL = 8;

  typedef struct packed {
    logic [3:0] st;
    logic       req, we, iord, irw, mdrw, pcw;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [3:0] aluc;
    logic [1:0] rdst, m2r;
    logic       rw;
    logic [1:0] flt, flt2;
  } obs_t;

  typedef struct {
    obs_t  v;
    obs_t  m;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] op, funct;
  logic zero, mem_ready;
  logic mem_req, mem_we, iord, ir_write, mdr_write, pc_write, alu_src_a, reg_write;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg, fault;
  logic [3:0] alu_control, state;
  logic b_mem_req, b_mem_we, b_iord, b_ir_write, b_mdr_write, b_pc_write, b_alu_src_a, b_reg_write;
  logic [1:0] b_pc_src, b_alu_src_b, b_reg_dst, b_mem_to_reg, b_fault;
  logic [3:0] b_alu_control, b_state;

  obs_t act, ev, em;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  logic [1:0] mflt = 2'b00;
  logic [1:0] mflt2 = 2'b00;

  always #5 clk = ~clk;

  mips_mcp_ctrl #(.TIMEOUT_W(8), .MEM_TIMEOUT(TO), .EN_BNE(1), .EN_JAL(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .fault(fault), .state(state)
  );

  // Same inputs, bne disabled: diverges only by trapping on the first bne.
  mips_mcp_ctrl #(.TIMEOUT_W(8), .MEM_TIMEOUT(TO), .EN_BNE(0), .EN_JAL(1)) dut_nobne (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .iord(b_iord), .ir_write(b_ir_write),
    .mdr_write(b_mdr_write), .pc_write(b_pc_write), .pc_src(b_pc_src), .alu_src_a(b_alu_src_a),
    .alu_src_b(b_alu_src_b), .alu_control(b_alu_control), .reg_dst(b_reg_dst),
    .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write), .fault(b_fault), .state(b_state)
  );

  assign act = {state, mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_control, reg_dst, mem_to_reg, reg_write, fault, b_fault};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if ((act & e.m) !== (e.v & e.m)) begin
        miscompares++;
        $display("FAIL %s @%0t: got %h (state %0d) expected %h (state %0d) mask %h",
                 e.tag, $time, act, act.st, e.v, e.v.st, e.m);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h00:   return (f == 6'h08) ? C_JR : C_RT;
      6'h04, 6'h05: return C_BR;
      6'h08:   return C_ADDI;
      6'h02:   return C_J;
      6'h03:   return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  // {legal, alu code} for an R-type funct.
  function automatic logic [4:0] alu_of(input logic [5:0] f);
    case (f)
      6'h20:   return 5'b1_0010;
      6'h22:   return 5'b1_0110;
      6'h24:   return 5'b1_0000;
      6'h25:   return 5'b1_0001;
      6'h27:   return 5'b1_1100;
      6'h2A:   return 5'b1_0111;
      default: return 5'b0_0000;
    endcase
  endfunction

  task automatic beg(input logic [3:0] st);
    ev = '0; em = '0;
    ev.st = st;   em.st = '1;
    em.req = 1'b1; em.irw = 1'b1; em.mdrw = 1'b1; em.pcw = 1'b1; em.rw = 1'b1;
    ev.flt = mflt; em.flt = '1;
    ev.flt2 = mflt2; em.flt2 = '1;
  endtask

  task automatic mem(input logic we, input logic ad);
    ev.req = 1'b1;
    ev.we = we;   em.we = 1'b1;
    ev.iord = ad; em.iord = 1'b1;
  endtask

  task automatic alu(input logic a, input logic [1:0] b, input logic [3:0] c);
    ev.srca = a; em.srca = 1'b1;
    ev.srcb = b; em.srcb = '1;
    ev.aluc = c; em.aluc = '1;
  endtask

  task automatic pcs(input logic [1:0] s, input logic w);
    ev.pcsrc = s; em.pcsrc = '1;
    ev.pcw = w;
  endtask

  task automatic wb(input logic [1:0] d, input logic [1:0] m);
    ev.rw = 1'b1;
    ev.rdst = d; em.rdst = '1;
    ev.m2r = m;  em.m2r = '1;
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.v = ev; e.m = em; e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    zero = 1'($urandom);
    mem_ready = 1'($urandom);
  endtask

  task automatic set_flt(input logic [1:0] f);
    mflt = f;
    if (mflt2 == 2'b00) mflt2 = f;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_strobes", 32'({ir_write, pc_write, mdr_write, reg_write, mem_we}), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_nobne", 32'(b_fault), 32'd0);
    mflt = 2'b00; mflt2 = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_req_iord", 32'({mem_req, iord}), 32'b10);
  endtask

  task automatic trap_tail();
    repeat (2) begin
      noise();
      beg(4'd15);
      push("trap");
    end
    do_reset();
  endtask

  // kind 0 = instruction fetch, 1 = load, 2 = store
  task automatic mem_phase(input int kind, input int waits, output bit done);
    logic [3:0] st;
    st = (kind == 0) ? 4'd0 : (kind == 1) ? 4'd3 : 4'd5;
    done = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      zero = 1'($urandom);
      if (kind == 0) begin op = 6'($urandom); funct = 6'($urandom); end
      mem_ready = (k == waits);
      beg(st);
      mem(kind == 2, kind != 0);
      if (k == waits) begin
        if (kind == 0) begin
          ev.irw = 1'b1;
          alu(1'b0, 2'b01, 4'b0010);
          pcs(2'b00, 1'b1);
        end
        if (kind == 1) ev.mdrw = 1'b1;
        push(kind == 0 ? "fetch" : kind == 1 ? "memrd" : "memwr");
        done = 1'b1;
      end else begin
        push("mem_wait");
        if (k == TO - 1) begin
          set_flt(2'b10);
          break;
        end
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int wf, input int wm);
    bit done;
    int c;
    logic [4:0] la;
    mem_phase(0, wf, done);
    if (!done) begin trap_tail(); return; end
    op = o; funct = f;
    noise();
    c = cls_of(o, f);
    beg(4'd1); alu(1'b0, 2'b11, 4'b0010);
    push("decode");
    if (o == 6'h05 && mflt2 == 2'b00) mflt2 = 2'b01;
    if (c == C_ILL) begin set_flt(2'b01); trap_tail(); return; end
    noise();
    case (c)
      C_LW, C_SW: begin
        beg(4'd2); alu(1'b1, 2'b10, 4'b0010);
        push("memadr");
        mem_phase(c == C_LW ? 1 : 2, wm, done);
        if (!done) begin trap_tail(); return; end
        if (c == C_LW) begin
          noise();
          beg(4'd4); wb(2'b00, 2'b01);
          push("memwb");
        end
      end
      C_RT: begin
        la = alu_of(f);
        beg(4'd6);
        alu(1'b1, 2'b00, la[3:0]);
        if (!la[4]) em.aluc = '0;
        push("rtype");
        if (!la[4]) begin set_flt(2'b01); trap_tail(); return; end
        noise();
        beg(4'd7); wb(2'b01, 2'b00);
        push("aluwb_r");
      end
      C_ADDI: begin
        beg(4'd8); alu(1'b1, 2'b10, 4'b0010);
        push("addi");
        noise();
        beg(4'd7); wb(2'b00, 2'b00);
        push("aluwb_i");
      end
      C_BR: begin
        zero = z;
        beg(4'd9); alu(1'b1, 2'b00, 4'b0110);
        pcs(2'b01, (o == 6'h05) ? !z : z);
        push("branch");
      end
      C_J: begin
        beg(4'd10); pcs(2'b10, 1'b1);
        push("jump");
      end
      C_JAL: begin
        beg(4'd11); pcs(2'b10, 1'b1); wb(2'b10, 2'b10);
        push("jal");
      end
      default: begin
        beg(4'd12); pcs(2'b11, 1'b1);
        push("jr");
      end
    endcase
  endtask

  initial begin
    logic [5:0] legal_f [6];
    bit done;
    legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("init_state", 32'(state), 32'd0);
    chk("init_mem_req", 32'(mem_req), 32'd0);
    chk("init_ir_write", 32'(ir_write), 32'd0);
    chk("init_fault", 32'(fault), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("init_req_iord", 32'({mem_req, iord}), 32'b10);

    run_instr(6'h23, 6'h00, 1'b0, 3, 0);        // lw, fetch waits 3
    run_instr(6'h00, 6'h22, 1'b0, 0, 0);        // sub
    run_instr(6'h04, 6'h00, 1'b1, 1, 0);        // beq taken
    run_instr(6'h05, 6'h00, 1'b1, 0, 0);        // bne not taken; traps the bne-less copy
    run_instr(6'h03, 6'h00, 1'b0, 2, 0);        // jal
    run_instr(6'h00, 6'h08, 1'b0, 0, 0);        // jr
    run_instr(6'h08, 6'h00, 1'b0, 0, 0);        // addi
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);        // j
    run_instr(6'h2B, 6'h00, 1'b0, 0, 0);        // sw zero-wait
    run_instr(6'h23, 6'h00, 1'b0, TO - 1, TO - 1); // ready on the last allowed cycle
    run_instr(6'h2B, 6'h00, 1'b0, 0, TO + 2);   // store times out
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);        // illegal opcode
    run_instr(6'h00, 6'h21, 1'b0, 0, 0);        // illegal funct
    run_instr(6'h00, 6'h20, 1'b0, TO + 1, 0);   // fetch times out

    // Reset asserted mid-load, together with mem_ready.
    mem_phase(0, 0, done);
    op = 6'h23; funct = 6'h00; noise();
    beg(4'd1); alu(1'b0, 2'b11, 4'b0010); push("decode");
    noise(); beg(4'd2); alu(1'b1, 2'b10, 4'b0010); push("memadr");
    mem_ready = 1'b0; beg(4'd3); mem(1'b0, 1'b1); push("memrd_wait");
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("midrd_mem_req", 32'(mem_req), 32'd0);
    chk("midrd_mdr_write", 32'(mdr_write), 32'd0);
    do_reset();

    for (int n = 0; n < 150; n++) begin
      logic [5:0] o, f;
      int wf, wm;
      f = 6'($urandom);
      case ($urandom_range(11, 0))
        0:       o = 6'h23;
        1:       o = 6'h2B;
        2, 3:    begin o = 6'h00; f = legal_f[$urandom_range(5, 0)]; end
        4:       o = 6'h04;
        5:       o = 6'h05;
        6:       o = 6'h08;
        7:       o = 6'h02;
        8:       o = 6'h03;
        9:       begin o = 6'h00; f = 6'h08; end
        10:      o = 6'($urandom);
        default: o = 6'h00;
      endcase
      wf = ($urandom_range(15, 0) == 0) ? TO + 1 : int'($urandom_range(TO - 1, 0));
      wm = ($urandom_range(7, 0) == 0) ? TO : int'($urandom_range(TO - 1, 0));
      run_instr(o, f, 1'($urandom), wf, wm);
    end

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
